// File: rtl/hamming_frame_decoder.sv
// hamming_frame_decoder: serial Hamming(7,4) frame receiver with header hunt and one-entry output buffer.
// Define HAMMING_DEC_CORRECT_EN to correct single-bit errors; otherwise errors are only flagged.
module hamming_frame_decoder #(
  parameter logic [7:0] HDR_MAIN = 8'h7E,
  parameter logic [7:0] HDR_ALT = 8'h6E,
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             data_in,
  input  logic             data_valid,
  input  logic             out_ready,
  output logic [31:0]      data_out,
  output logic             out_valid,
  output logic [7:0]       err_mask,
  output logic             hdr_alt,
  output logic             in_sync,
  output logic             overflow,
  output logic [CNT_W-1:0] frames_ok
);
  typedef enum logic {HUNT, PAYLOAD} state_t;
  state_t state, state_nx;
  logic [6:0] hdr_sr;
  logic [54:0] pay_sr;
  logic [5:0] bit_cnt;
  logic alt_q;
  logic [7:0] hdr_nx;
  logic [55:0] pay_nx;
  logic hdr_hit, last, load;
  logic [31:0] dec_word;
  logic [7:0] dec_err;
  assign hdr_nx = {hdr_sr, data_in};
  assign pay_nx = {pay_sr, data_in};
  assign hdr_hit = hdr_nx == HDR_MAIN || hdr_nx == HDR_ALT;
  assign last = state == PAYLOAD && data_valid && bit_cnt == 6'd55;
  assign load = last && (!out_valid || out_ready);
  assign in_sync = state == PAYLOAD;
  // decode straight from the post-shift payload so the word is ready on the bit-55 edge
  for (genvar k = 0; k < 8; k++) begin : g_cw
    logic [6:0] cw;
    logic [2:0] syn;
    assign cw = pay_nx[7*k +: 7];
    assign syn = {cw[3] ^ cw[4] ^ cw[5] ^ cw[6], cw[1] ^ cw[2] ^ cw[5] ^ cw[6], cw[0] ^ cw[2] ^ cw[4] ^ cw[6]};
`ifdef HAMMING_DEC_CORRECT_EN
    assign dec_word[4*k +: 4] = {cw[6], cw[5], cw[4], cw[2]} ^ {syn == 3'd7, syn == 3'd6, syn == 3'd5, syn == 3'd3};
`else
    assign dec_word[4*k +: 4] = {cw[6], cw[5], cw[4], cw[2]};
`endif
    assign dec_err[k] = |syn;
  end
  always_comb begin
    state_nx = state;
    state_nx = state == HUNT ? (data_valid && hdr_hit ? PAYLOAD : HUNT) : (last ? HUNT : PAYLOAD);
  end
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state <= HUNT;
      hdr_sr <= '0;
      pay_sr <= '0;
      bit_cnt <= '0;
      alt_q <= 1'b0;
      data_out <= '0;
      out_valid <= 1'b0;
      err_mask <= '0;
      hdr_alt <= 1'b0;
      overflow <= 1'b0;
      frames_ok <= '0;
    end else begin
      state <= state_nx;
      if (data_valid && state == HUNT) begin
        hdr_sr <= hdr_nx[6:0];
        if (hdr_hit) begin
          alt_q <= hdr_nx == HDR_ALT;
          bit_cnt <= '0;
        end
      end
      if (data_valid && state == PAYLOAD) begin
        pay_sr <= pay_nx[54:0];
        bit_cnt <= bit_cnt + 6'd1;
      end
      // a fresh hunt must not reuse payload bits as a partial header
      if (last)
        hdr_sr <= '0;
      if (load) begin
        data_out <= dec_word;
        err_mask <= dec_err;
        hdr_alt <= alt_q;
        frames_ok <= &frames_ok ? frames_ok : frames_ok + CNT_W'(1);
      end
      out_valid <= load || (out_valid && !out_ready);
      if (last && !load)
        overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_hamming_frame_decoder.sv
// tb_hamming_frame_decoder: directed and randomized frames checked against a behavioural receiver model.
module tb_hamming_frame_decoder;
  localparam int CW = 4;
  localparam logic [7:0] H_MAIN = 8'h7E;
  localparam logic [7:0] H_ALT = 8'h6E;
  logic clk_in = 1'b0;
  logic rst;
  logic data_in = 1'b0;
  logic data_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [31:0] data_out;
  logic out_valid;
  logic [7:0] err_mask;
  logic hdr_alt;
  logic in_sync;
  logic overflow;
  logic [CW-1:0] frames_ok;
  int total = 0;
  int bad = 0;
  bit rnd_rdy = 0;

  hamming_frame_decoder #(.HDR_MAIN(H_MAIN), .HDR_ALT(H_ALT), .CNT_W(CW)) dut (
    .clk_in(clk_in), .rst(rst), .data_in(data_in), .data_valid(data_valid), .out_ready(out_ready),
    .data_out(data_out), .out_valid(out_valid), .err_mask(err_mask), .hdr_alt(hdr_alt),
    .in_sync(in_sync), .overflow(overflow), .frames_ok(frames_ok)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Hamming(7,4) with the syndrome defined as the XOR of the indices of all set positions
  function automatic logic [6:0] enc(logic [3:0] n);
    logic [6:0] c;
    int s;
    c = '0;
    s = 0;
    c[2] = n[0]; c[4] = n[1]; c[5] = n[2]; c[6] = n[3];
    for (int p = 1; p <= 7; p++) if (c[p-1]) s ^= p;
    c[0] = s[0]; c[1] = s[1]; c[3] = s[2];
    return c;
  endfunction

  function automatic logic [39:0] dec(logic [55:0] pay);
    logic [6:0] c;
    logic [7:0] m;
    logic [31:0] d;
    int s;
    m = '0;
    d = '0;
    for (int k = 0; k < 8; k++) begin
      c = pay[7*k +: 7];
      s = 0;
      for (int p = 1; p <= 7; p++) if (c[p-1]) s ^= p;
      if (s != 0) begin
        m[k] = 1'b1;
`ifdef HAMMING_DEC_CORRECT_EN
        c[s-1] = ~c[s-1];
`endif
      end
      d[4*k +: 4] = {c[6], c[5], c[4], c[2]};
    end
    return {m, d};
  endfunction

  function automatic logic [63:0] frame(logic [7:0] h, logic [31:0] w);
    logic [63:0] f;
    f[63:56] = h;
    for (int k = 0; k < 8; k++) f[7*k +: 7] = enc(w[4*k +: 4]);
    return f;
  endfunction

  bit m_sync, m_alt_pend, m_valid, m_alt, m_ovf;
  int m_cnt, m_ok;
  logic [7:0] m_hist, m_mask;
  logic [55:0] m_pay;
  logic [31:0] m_data;

  task automatic model_reset();
    m_sync = 0; m_alt_pend = 0; m_valid = 0; m_alt = 0; m_ovf = 0;
    m_cnt = 0; m_ok = 0; m_hist = '0; m_mask = '0; m_pay = '0; m_data = '0;
  endtask

  task automatic model_step();
    bit done;
    logic [39:0] r;
    done = 0;
    if (data_valid) begin
      if (!m_sync) begin
        m_hist = {m_hist[6:0], data_in};
        if (m_hist == H_MAIN || m_hist == H_ALT) begin
          m_sync = 1;
          m_cnt = 0;
          m_alt_pend = m_hist == H_ALT;
        end
      end else begin
        m_pay = {m_pay[54:0], data_in};
        m_cnt++;
        if (m_cnt == 56) begin
          done = 1;
          m_sync = 0;
          m_hist = '0;
        end
      end
    end
    if (done && m_valid && !out_ready) m_ovf = 1;
    else if (done) begin
      r = dec(m_pay);
      m_data = r[31:0];
      m_mask = r[39:32];
      m_alt = m_alt_pend;
      m_valid = 1;
      if (m_ok < (1 << CW) - 1) m_ok++;
    end else if (out_ready) m_valid = 0;
  endtask

  always @(posedge clk_in or negedge rst) begin
    if (!rst) model_reset();
    else model_step();
  end

  always @(negedge clk_in) begin
    check("cyc_out_valid", 64'(out_valid), 64'(m_valid));
    check("cyc_data_out", 64'(data_out), 64'(m_data));
    check("cyc_err_mask", 64'(err_mask), 64'(m_mask));
    check("cyc_hdr_alt", 64'(hdr_alt), 64'(m_alt));
    check("cyc_in_sync", 64'(in_sync), 64'(m_sync));
    check("cyc_overflow", 64'(overflow), 64'(m_ovf));
    check("cyc_frames_ok", 64'(frames_ok), 64'(m_ok));
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(int n);
    repeat (n) begin
      data_valid = 1'b0;
      data_in = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic send_bits(logic [63:0] f, int hi, int lo, bit gap);
    for (int i = hi; i >= lo; i--) begin
      if (gap && i != hi) idle(1);
      data_valid = 1'b1;
      data_in = f[i];
      tick();
    end
    data_valid = 1'b0;
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_data_out"}, 64'(data_out), 64'd0);
    check({tag, "_err_mask"}, 64'(err_mask), 64'd0);
    check({tag, "_hdr_alt"}, 64'(hdr_alt), 64'd0);
    check({tag, "_in_sync"}, 64'(in_sync), 64'd0);
    check({tag, "_overflow"}, 64'(overflow), 64'd0);
    check({tag, "_frames_ok"}, 64'(frames_ok), 64'd0);
  endtask

  initial begin
    logic [63:0] f, fa, fb, fc, flips;
    logic [20:0] seq;
    logic [7:0] h;
    bit hit;
    rst = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    check_reset_vals("rst");
    check("pin_enc1", 64'(enc(4'h1)), 64'h07);
    check("pin_encF", 64'(enc(4'hF)), 64'h7F);
    f = frame(H_MAIN, 32'hDEADBEEF);
    check("pin_dec", 64'(dec(f[55:0])), 64'h00DEADBEEF);
    @(negedge clk_in) rst = 1'b1;
    tick();
    // clean frame, in_sync right after the header
    send_bits(f, 63, 56, 0);
    check("clean_sync_up", 64'(in_sync), 64'd1);
    send_bits(f, 55, 0, 0);
    check("clean_valid", 64'(out_valid), 64'd1);
    check("clean_data", 64'(data_out), 64'hDEADBEEF);
    check("clean_err", 64'(err_mask), 64'd0);
    check("clean_alt", 64'(hdr_alt), 64'd0);
    check("clean_ok", 64'(frames_ok), 64'd1);
    check("clean_sync_dn", 64'(in_sync), 64'd0);
    idle(1);
    check("clean_valid_1cyc", 64'(out_valid), 64'd0);
    // single-bit errors in codewords 7 and 0 (both land on parity positions)
    send_bits(frame(H_MAIN, 32'h12345678) ^ ((64'd1 << 50) | (64'd1 << 3)), 63, 0, 0);
    check("err_mask", 64'(err_mask), 64'h81);
`ifdef HAMMING_DEC_CORRECT_EN
    check("err_data", 64'(data_out), 64'h12345678);
`endif
    check("err_ok", 64'(frames_ok), 64'd2);
    idle(2);
    // payload ending in 0111111 followed by a 0 must not look like a header
    send_bits(frame(H_MAIN, 32'hA5A5A5A7) ^ 64'h0B, 63, 0, 0);
    check("tail_ok0", 64'(frames_ok), 64'd3);
    send_bits(64'd0, 56, 0, 0);
    check("tail_sync", 64'(in_sync), 64'd0);
    check("tail_ok1", 64'(frames_ok), 64'd3);
    // resync after 13 header-free random bits
    do begin
      seq = {13'($urandom), H_ALT};
      h = '0;
      hit = 0;
      for (int i = 20; i >= 1; i--) begin
        h = {h[6:0], seq[i]};
        hit |= (h == H_MAIN || h == H_ALT);
      end
    end while (hit);
    send_bits({43'd0, seq}, 20, 8, 0);
    send_bits(frame(H_ALT, 32'h0000FFFF), 63, 0, 0);
    check("resync_data", 64'(data_out), 64'h0000FFFF);
    check("resync_alt", 64'(hdr_alt), 64'd1);
    check("resync_ok", 64'(frames_ok), 64'd4);
    idle(2);
    // backpressure: A held, B dropped, C loads on the popping edge
    fa = frame(H_MAIN, 32'hA1B2C3D4);
    fb = frame(H_ALT, 32'h0BADF00D);
    fc = frame(H_MAIN, 32'hCAFEF00D);
    out_ready = 1'b0;
    send_bits(fa, 63, 0, 0);
    send_bits(fb, 63, 0, 0);
    check("bp_data_a", 64'(data_out), 64'hA1B2C3D4);
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_ovf", 64'(overflow), 64'd1);
    check("bp_ok_a", 64'(frames_ok), 64'd5);
    check("bp_alt_a", 64'(hdr_alt), 64'd0);
    send_bits(fc, 63, 1, 0);
    out_ready = 1'b1;
    send_bits(fc, 0, 0, 0);
    check("bp_data_c", 64'(data_out), 64'hCAFEF00D);
    check("bp_valid_c", 64'(out_valid), 64'd1);
    check("bp_ok_c", 64'(frames_ok), 64'd6);
    idle(2);
    check("bp_drain", 64'(out_valid), 64'd0);
    check("bp_ovf_sticky", 64'(overflow), 64'd1);
    // gapped input
    send_bits(frame(H_MAIN, 32'hDEADBEEF), 63, 0, 1);
    check("gap_valid", 64'(out_valid), 64'd1);
    check("gap_data", 64'(data_out), 64'hDEADBEEF);
    check("gap_err", 64'(err_mask), 64'd0);
    check("gap_ok", 64'(frames_ok), 64'd7);
    idle(1);
    check("gap_valid_1cyc", 64'(out_valid), 64'd0);
    // reset after payload bit 30
    f = frame(H_MAIN, 32'h13579BDF);
    send_bits(f, 63, 25, 0);
    check("mid_sync", 64'(in_sync), 64'd1);
    rst = 1'b0;
    #1;
    check_reset_vals("mid");
    @(negedge clk_in) rst = 1'b1;
    tick();
    send_bits(f, 63, 0, 0);
    check("mid_data", 64'(data_out), 64'h13579BDF);
    check("mid_ok", 64'(frames_ok), 64'd1);
    check("mid_valid", 64'(out_valid), 64'd1);
    idle(2);
    // randomized traffic: noise, random errors, gaps and ready
    rnd_rdy = 1;
    repeat (40) begin
      repeat ($urandom_range(0, 6)) begin
        data_valid = 1'($urandom_range(0, 1));
        data_in = 1'($urandom_range(0, 1));
        tick();
      end
      flips = '0;
      repeat ($urandom_range(0, 2)) flips ^= 64'd1 << $urandom_range(0, 55);
      send_bits(frame($urandom_range(0, 1) ? H_ALT : H_MAIN, $urandom) ^ flips, 63, 0, 1'($urandom_range(0, 1)));
    end
    rnd_rdy = 0;
    out_ready = 1'b1;
    idle(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
